// File: rtl/wave_stim_checker.sv
// -----------------------------------------------------------------------------
// wave_stim_checker
//   Stimulus generator and response checker for a single-bit DUT interface.
//   Drives a programmable waveform (constant, toggle, step, LFSR) on vint,
//   samples vout LATENCY cycles later and compares it against the driven bit.
//   Reports pass/fail, a saturating mismatch count and the index of the first
//   mismatching sample.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   run request, accepted only in IDLE or DONE
//   mode[1:0]      in   00 constant, 01 toggle, 10 step, 11 LFSR
//   init           in   initial waveform level
//   half_period[7:0] in toggle half-period / step position (0 acts as 1)
//   length         in   number of samples to drive
//   vint           out  stimulus to the DUT (registered)
//   vout           in   DUT response
//   busy           out  high in RUN and DRAIN
//   done           out  high in DONE
//   pass           out  valid with done: no mismatches seen
//   err_count      out  mismatch count, saturating
//   first_err_idx  out  sample index of the first mismatch, all-ones if none
// -----------------------------------------------------------------------------
module wave_stim_checker #(
  parameter int unsigned  LATENCY   = 1,
  parameter int unsigned  CNT_W     = 16,
  parameter logic [15:0]  LFSR_SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             init,
  input  logic [7:0]       half_period,
  input  logic [CNT_W-1:0] length,
  output logic             vint,
  input  logic             vout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero-latency build still declares one pipeline stage so no array is empty.
  localparam int unsigned      PIPE_D     = (LATENCY == 32'd0) ? 32'd1 : LATENCY;
  localparam logic [3:0]       DRAIN_INIT = 4'((LATENCY == 32'd0) ? 32'd0 : LATENCY - 32'd1);
  localparam logic [15:0]      SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONES   = {CNT_W{1'b1}};

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 feed bit 15).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             init_q, init_d;
  logic [7:0]       h_q, h_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       hcnt_q, hcnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             vint_q, vint_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [PIPE_D-1:0] pipe_vld_q, pipe_vld_d;
  logic [PIPE_D-1:0] pipe_exp_q, pipe_exp_d;
  logic [CNT_W-1:0]  pipe_idx_q [PIPE_D];
  logic [CNT_W-1:0]  pipe_idx_d [PIPE_D];

  logic             cmp_vld_s;
  logic             cmp_exp_s;
  logic [CNT_W-1:0] cmp_idx_s;
  logic             mismatch_s;
  logic [15:0]      lfsr_nx_s;
  logic [8:0]       hcnt_inc_s;
  logic             seg_end_s;

  // Select the sample being compared this cycle: the pipeline tail, or the live vint at zero latency.
  always_comb begin
    cmp_vld_s = 1'b0;
    cmp_exp_s = 1'b0;
    cmp_idx_s = CNT_ZERO;
    if (LATENCY == 32'd0) begin
      cmp_vld_s = (state_q == S_RUN);
      cmp_exp_s = vint_q;
      cmp_idx_s = idx_q;
    end else begin
      cmp_vld_s = pipe_vld_q[PIPE_D-1];
      cmp_exp_s = pipe_exp_q[PIPE_D-1];
      cmp_idx_s = pipe_idx_q[PIPE_D-1];
    end
    mismatch_s = cmp_vld_s && (vout != cmp_exp_s);
    lfsr_nx_s  = lfsr_step(lfsr_q);
    hcnt_inc_s = {1'b0, hcnt_q} + 9'd1;
    seg_end_s  = (hcnt_inc_s == {1'b0, h_q});
  end

  // Next-state, waveform, pipeline and error bookkeeping.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    init_d  = init_q;
    h_d     = h_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    lfsr_d  = lfsr_q;
    vint_d  = vint_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;

    // Expected bit, valid flag and sample index travel together down the delay line.
    pipe_vld_d[0] = (state_q == S_RUN);
    pipe_exp_d[0] = vint_q;
    pipe_idx_d[0] = idx_q;
    for (int i = 1; i < int'(PIPE_D); i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_exp_d[i] = pipe_exp_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end

    if (mismatch_s) begin
      if (err_q != CNT_ONES) begin
        err_d = err_q + CNT_ONE;
      end else begin
        err_d = err_q;
      end
      if (err_q == CNT_ZERO) begin
        first_d = cmp_idx_s;
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d   = err_q;
      first_d = first_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d     = mode;
          init_d     = init;
          h_d        = (half_period == 8'd0) ? 8'd1 : half_period;
          len_d      = length;
          idx_d      = CNT_ZERO;
          hcnt_d     = 8'd0;
          lfsr_d     = SEED_EFF;
          err_d      = CNT_ZERO;
          first_d    = CNT_ONES;
          pipe_vld_d = {PIPE_D{1'b0}};
          if (length == CNT_ZERO) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            // Sample 0 goes on vint in the cycle right after the start edge.
            vint_d  = (mode == 2'b11) ? SEED_EFF[0] : init;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_nx_s;
        if (idx_q == len_q - CNT_ONE) begin
          // Last sample is on vint now; vint keeps it after the run.
          if (LATENCY == 32'd0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == CNT_ZERO);
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          idx_d = idx_q + CNT_ONE;
          if (seg_end_s) begin
            hcnt_d = 8'd0;
          end else begin
            hcnt_d = hcnt_inc_s[7:0];
          end
          case (mode_q)
            2'b00: vint_d = init_q;
            2'b01: vint_d = seg_end_s ? ~vint_q : vint_q;
            2'b10: vint_d = seg_end_s ? ~init_q : vint_q;
            2'b11: vint_d = lfsr_nx_s[0];
            default: vint_d = vint_q;
          endcase
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == CNT_ZERO);
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any run without a report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      init_q     <= 1'b0;
      h_q        <= 8'd1;
      len_q      <= CNT_ZERO;
      idx_q      <= CNT_ZERO;
      hcnt_q     <= 8'd0;
      lfsr_q     <= SEED_EFF;
      vint_q     <= 1'b0;
      drain_q    <= 4'd0;
      err_q      <= CNT_ZERO;
      first_q    <= CNT_ONES;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pipe_vld_q <= {PIPE_D{1'b0}};
      pipe_exp_q <= {PIPE_D{1'b0}};
      for (int i = 0; i < int'(PIPE_D); i++) begin
        pipe_idx_q[i] <= CNT_ZERO;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      init_q     <= init_d;
      h_q        <= h_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hcnt_q     <= hcnt_d;
      lfsr_q     <= lfsr_d;
      vint_q     <= vint_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_exp_q <= pipe_exp_d;
      for (int i = 0; i < int'(PIPE_D); i++) begin
        pipe_idx_q[i] <= pipe_idx_d[i];
      end
    end
  end

  assign vint          = vint_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_wave_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_wave_stim_checker
//   Self-checking bench for wave_stim_checker (LATENCY=1). Expected waveforms
//   come from an arithmetic model of the waveform rules (k / h parity, step
//   threshold, shift-and-xor LFSR); vout is either a register loopback of vint,
//   tied low, or driven from the model with randomly injected bit flips.
// -----------------------------------------------------------------------------
module tb_wave_stim_checker;

  localparam int LAT = 1;
  localparam int CW  = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          init = 1'b0;
  logic [7:0]    half_period = 8'd0;
  logic [CW-1:0] length = 16'd0;
  logic          vint, vout, busy, done, pass;
  logic [CW-1:0] err_count, first_err_idx;

  logic vout_drv = 1'b0;
  logic lb_q = 1'b0;
  logic use_lb = 1'b0;

  int checks = 0;
  int errors = 0;

  int exp_w   [2048];
  bit flips   [2048];
  int obs_vint[2048];
  int done_j;
  int busy_cnt;

  assign vout = use_lb ? lb_q : vout_drv;

  wave_stim_checker #(.LATENCY(LAT), .CNT_W(CW), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .init(init),
    .half_period(half_period), .length(length), .vint(vint), .vout(vout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  always #5 clock = ~clock;

  // One-register loopback path standing in for a DUT with one cycle of latency.
  always @(posedge clock) lb_q <= vint;

  // Reference waveform built straight from the waveform definitions.
  function automatic void model_wave(input int m, input int iv, input int h, input int len);
    int he;
    int s;
    int fb;
    he = (h == 0) ? 1 : h;
    s  = 'hACE1;
    for (int k = 0; k < len; k++) begin
      case (m)
        0: exp_w[k] = iv;
        1: exp_w[k] = iv ^ ((k / he) % 2);
        2: exp_w[k] = (k >= he) ? 1 - iv : iv;
        default: begin
          exp_w[k] = s & 1;
          fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
          s  = (s >> 1) | (fb << 15);
        end
      endcase
    end
  endfunction

  function automatic void clear_flips();
    for (int k = 0; k < 2048; k++) flips[k] = 1'b0;
  endfunction

  // Issue one start and record vint/busy/done per cycle; vk: 0 model+flips, 1 tied low, 2 loopback.
  task automatic do_run(input int m, input int iv, input int h, input int len, input int vk);
    int win;
    win      = len + LAT + 3;
    done_j   = -1;
    busy_cnt = 0;
    @(negedge clock);
    start = 1'b1; mode = m[1:0]; init = iv[0]; half_period = h[7:0]; length = len[CW-1:0];
    use_lb = (vk == 2);
    @(negedge clock);
    start = 1'b0;
    mode = 2'($urandom); init = 1'($urandom); half_period = 8'($urandom); length = 16'($urandom);
    for (int j = 0; j < win; j++) begin
      if (j > 0) @(negedge clock);
      obs_vint[j] = int'(vint);
      if (busy) busy_cnt++;
      if (done && done_j < 0) done_j = j;
      if (vk == 1) vout_drv = 1'b0;
      else if (j >= LAT && j - LAT < len) vout_drv = exp_w[j-LAT][0] ^ flips[j-LAT];
      else vout_drv = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; vout_drv = 1'b0; use_lb = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (vint !== 1'b0) begin errors++; $display("FAIL reset_vint got %0b want 0", vint); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b want 0", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if (first_err_idx !== 16'hFFFF) begin errors++; $display("FAIL reset_first got %h want ffff", first_err_idx); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %0b done %0b want 0 0", busy, done); end
  endtask

  task automatic test_toggle_loopback();
    int tv [8];
    int bad;
    tv = '{0, 0, 1, 1, 0, 0, 1, 1};
    model_wave(1, 0, 2, 8);
    do_run(1, 0, 2, 8, 2);
    bad = 0;
    for (int k = 0; k < 8; k++) if (obs_vint[k] != tv[k] || exp_w[k] != tv[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL toggle_seq bad samples %0d want 0", bad); end
    checks++; if (done_j != 9) begin errors++; $display("FAIL toggle_done_cycle got %0d want 9", done_j); end
    checks++; if (busy_cnt != 9) begin errors++; $display("FAIL toggle_busy_cycles got %0d want 9", busy_cnt); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL toggle_pass got %0b want 1", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL toggle_err got %0d want 0", err_count); end
    checks++; if (first_err_idx !== 16'hFFFF) begin errors++; $display("FAIL toggle_first got %h want ffff", first_err_idx); end
  endtask

  task automatic test_lfsr_loopback();
    int bad;
    model_wave(3, 0, 0, 1000);
    do_run(3, 0, 0, 1000, 2);
    bad = 0;
    for (int k = 0; k < 4; k++) if (obs_vint[k] != exp_w[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_first4 bad %0d want 0 (got %0d%0d%0d%0d)", bad, obs_vint[0], obs_vint[1], obs_vint[2], obs_vint[3]); end
    bad = 0;
    for (int k = 0; k < 1000; k++) if (obs_vint[k] != exp_w[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_seq bad samples %0d want 0", bad); end
    checks++; if (pass !== 1'b1 || err_count !== 16'd0) begin errors++; $display("FAIL lfsr_pass pass %0b err %0d want 1 0", pass, err_count); end
    checks++; if (done_j != 1000 + LAT) begin errors++; $display("FAIL lfsr_done_cycle got %0d want %0d", done_j, 1000 + LAT); end
  endtask

  task automatic test_const_zero();
    model_wave(0, 1, 0, 5);
    do_run(0, 1, 0, 5, 1);
    checks++; if (err_count !== 16'd5) begin errors++; $display("FAIL const0_err got %0d want 5", err_count); end
    checks++; if (first_err_idx !== 16'd0) begin errors++; $display("FAIL const0_first got %0d want 0", first_err_idx); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL const0_pass pass %0b done %0b want 0 1", pass, done); end
  endtask

  task automatic test_step_zero();
    int bad;
    model_wave(2, 0, 3, 6);
    do_run(2, 0, 3, 6, 1);
    bad = 0;
    for (int k = 0; k < 6; k++) if (obs_vint[k] != exp_w[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL step_seq bad samples %0d want 0", bad); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL step_err got %0d want 3", err_count); end
    checks++; if (first_err_idx !== 16'd3) begin errors++; $display("FAIL step_first got %0d want 3", first_err_idx); end
  endtask

  task automatic test_random();
    int m, iv, h, len, bad, e_err, e_first, e_done, e_busy;
    for (int it = 0; it < 25; it++) begin
      m = int'($urandom_range(0, 3)); iv = int'($urandom_range(0, 1));
      h = int'($urandom_range(0, 5)); len = int'($urandom_range(0, 60));
      clear_flips();
      e_err = 0; e_first = 'hFFFF;
      for (int k = 0; k < len; k++) begin
        flips[k] = ($urandom_range(0, 7) == 0);
        if (flips[k]) begin
          if (e_err == 0) e_first = k;
          e_err++;
        end
      end
      e_done = (len == 0) ? 0 : len + LAT;
      e_busy = (len == 0) ? 0 : len + LAT;
      model_wave(m, iv, h, len);
      do_run(m, iv, h, len, 0);
      bad = 0;
      for (int k = 0; k < len; k++) if (obs_vint[k] != exp_w[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_seq mode %0d h %0d len %0d bad %0d want 0", it, m, h, len, bad); end
      checks++; if (done_j != e_done || busy_cnt != e_busy) begin errors++; $display("FAIL rnd%0d_timing done %0d busy %0d want %0d %0d", it, done_j, busy_cnt, e_done, e_busy); end
      checks++; if (err_count !== 16'(e_err)) begin errors++; $display("FAIL rnd%0d_err got %0d want %0d", it, err_count, e_err); end
      checks++; if (first_err_idx !== 16'(e_first)) begin errors++; $display("FAIL rnd%0d_first got %0d want %0d", it, first_err_idx, e_first); end
      checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL rnd%0d_pass got %0b want %0b", it, pass, e_err == 0); end
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int bad;
    model_wave(1, 1, 3, 30);
    clear_flips();
    @(negedge clock);
    start = 1'b1; mode = 2'b01; init = 1'b1; half_period = 8'd3; length = 16'd30; use_lb = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clock);
      if (obs_vint[0] >= 0 && int'(vint) != exp_w[j]) bad++;
      if (j == 3) begin
        start = 1'b1; mode = 2'b00; init = 1'b0; length = 16'd2;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_start_seq bad samples %0d want 0", bad); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL busy_start_state busy %0b done %0b want 1 0", busy, done); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || vint !== 1'b0) begin errors++; $display("FAIL midrun_reset busy %0b done %0b vint %0b want 0 0 0", busy, done, vint); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy %0b done %0b want 0 0", busy, done); end
    model_wave(2, 1, 2, 10);
    clear_flips();
    do_run(2, 1, 2, 10, 0);
    checks++; if (pass !== 1'b1 || err_count !== 16'd0 || done_j != 10 + LAT) begin errors++; $display("FAIL rerun_after_reset pass %0b err %0d done %0d want 1 0 %0d", pass, err_count, done_j, 10 + LAT); end
  endtask

  task automatic test_length_zero();
    int bz;
    model_wave(0, 1, 0, 4);
    do_run(0, 1, 0, 4, 1);
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL pre_len0_err got %0d want 4", err_count); end
    @(negedge clock);
    start = 1'b1; length = 16'd0; mode = 2'b01;
    @(negedge clock);
    start = 1'b0;
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL len0_done done %0b pass %0b want 1 1", done, pass); end
    checks++; if (err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin errors++; $display("FAIL len0_cleared err %0d first %h want 0 ffff", err_count, first_err_idx); end
    bz = int'(busy);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      if (busy) bz++;
    end
    checks++; if (bz != 0) begin errors++; $display("FAIL len0_busy cycles %0d want 0", bz); end
    model_wave(1, 0, 1, 12);
    clear_flips();
    do_run(1, 0, 1, 12, 0);
    checks++; if (pass !== 1'b1 || err_count !== 16'd0 || done_j != 12 + LAT) begin errors++; $display("FAIL rerun_from_done pass %0b err %0d done %0d want 1 0 %0d", pass, err_count, done_j, 12 + LAT); end
  endtask

  initial begin
    test_reset();
    test_toggle_loopback();
    test_lfsr_loopback();
    test_const_zero();
    test_step_zero();
    test_random();
    test_start_ignored_and_reset();
    test_length_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_stim_checker.md
Name: wave_stim_checker

Overview:
Synthesizable stimulus generator and response checker: the driving and checking end of the single-bit vint/vout interface. It drives a programmable waveform onto the DUT input (constant, toggle, step or pseudo-random), samples the DUT output after a fixed latency, and compares each sample against the value it drove. It reports pass/fail, a mismatch count and the index of the first mismatch. It lets the single-bit DUT interface be tested in hardware (FPGA board) as well as in simulation benches.

Parameters:
LATENCY, 1, cycles from driving vint to the matching vout being valid; legal range 0..15
CNT_W, 16, width of length, sample index and error counters
LFSR_SEED, 16'hACE1, seed loaded into the LFSR at every accepted start; a value of 0 is replaced by 16'h0001

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a run; accepted only in IDLE or DONE
mode  in  2  waveform select: 00 constant, 01 toggle, 10 step, 11 LFSR
init  in  1  initial level of the waveform
half_period  in  8  toggle half-period / step position in samples; 0 is treated as 1
length  in  CNT_W  number of samples to drive
vint  out  1  stimulus driven to the DUT input
vout  in  1  DUT response
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; held until the next accepted start or reset
pass  out  1  valid while done=1: 1 when err_count == 0
err_count  out  CNT_W  number of mismatches; saturates at all-ones
first_err_idx  out  CNT_W  sample index of the first mismatch; all-ones if there is none

Behaviour:
- Reset (async assert; deassert takes effect at the next edge): state IDLE, vint=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, LFSR=LFSR_SEED, delay pipeline cleared. Reset in the middle of a run aborts it immediately, with no report.
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- In IDLE or DONE, start=1 latches mode, init, half_period and length. On the same edge it clears the counters and the pipeline, and sets first_err_idx to all-ones.
- length=0 means the next state is DONE with pass=1. Otherwise the next state is RUN.
- start while busy=1 is ignored. The config inputs are sampled only when start is accepted.
- Sample index k runs from 0 to length-1. If start is accepted at edge T, sample k is on vint during cycle T+1+k. vint is registered.
- RUN moves to DRAIN after sample length-1, or directly to DONE when LATENCY=0. DRAIN lasts exactly LATENCY cycles and then moves to DONE.
- done rises at cycle T+1+length+LATENCY.
- Waveforms (h = half_period, with 0 mapped to 1):
  - constant: vint=init.
  - toggle: vint=init for samples 0..h-1, then inverts every h samples.
  - step: vint=init for samples 0..h-1, then ~init for the rest of the run.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. vint=lfsr[0]. The LFSR shifts once per RUN cycle, after each sample is driven.
- Checking:
  - The expected bit and a valid flag go through a LATENCY-deep shift register.
  - When the delayed valid flag is 1, vout is compared against the delayed expected bit at the rising edge.
  - LATENCY=0 compares vout against vint in the same cycle.
  - A mismatch increments err_count (saturating at all-ones). On the first mismatch, first_err_idx takes that sample's index.
- After the run, vint holds the last driven value until the next start or reset. Results hold in DONE.
- Samples are compared only while their valid flag is set. vout is a don't-care in IDLE and DONE.

Test Plan:
- Loopback vout=vint, LATENCY=1, mode=01, init=0, h=2, length=8 -> vint sequence 0,0,1,1,0,0,1,1; done at T+10; pass=1; err_count=0; first_err_idx=16'hFFFF.
- Loopback through 1 register, mode=11, length=1000 -> pass=1; the first 4 vint values match the reference LFSR model seeded 16'hACE1.
- vout tied to 0, mode=00, init=1, length=5 -> err_count=5, first_err_idx=0, pass=0.
- vout tied to 0, mode=10, init=0, h=3, length=6 -> err_count=3, first_err_idx=3.
- Start pulse during RUN, then reset_n low for 1 cycle mid-run -> the extra start has no effect; after reset busy=0, done=0, vint=0. A new start runs normally.
- length=0 -> done=1 one cycle after start, with pass=1 and busy never asserted. Repeated start from DONE re-runs the test and clears err_count.
